csa_pipe: RTL
=============

# csa_pipe

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on input and output. The datapath is split into `NB = WIDTH/BLK` blocks, and each pipeline stage resolves one block's carry-select. The block is the wide, throughput-oriented successor to the team's fixed 8-bit carry-select adder, and is used wherever the ALU datapath needs adds wider than 8 bits at full clock rate.

## Interface
- `WIDTH`, 16: operand and sum width. Must be a multiple of `BLK`; elaboration fails otherwise.
- `BLK`, 4: bits per carry-select block. Must be at least 1.
- `clk` in 1: the single clock; everything is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: the operand beat is valid.
- `in_ready` out 1: the block can accept a beat this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry in. Ignored when `sub=1`.
- `sub` in 1: 0 computes `a+b+cin`; 1 computes `a-b`.
- `out_valid` out 1: the result beat is valid.
- `out_ready` in 1: the consumer accepts the result.
- `sum` out WIDTH: the result.
- `cout` out 1: carry out of the MSB. When subtracting, 1 means no borrow.
- `ovf` out 1: two's-complement signed overflow.

## Operation
**Operand preparation**
- Effective operands: `bx = sub ? ~b : b` and `c0 = sub ? 1 : cin`.
- Block j covers bits `[j*BLK +: BLK]`.
- For each block, two candidate sums are computed on entry: one with carry-in 0 and one with carry-in 1.
- Each candidate is `BLK+1` bits, where the top bit is that block's carry-out.

**Pipeline structure**
- The pipeline has `NB` register stages, S1..SNB.
- Each stage holds:
  - a valid bit;
  - the resolved low sum bits;
  - the carry into the next unresolved block;
  - the candidate pairs for the unresolved blocks;
  - the operand MSBs `a[W-1]` and `bx[W-1]`, needed for `ovf`.
- Stage S(j+1) selects block j's candidate using the carry registered by the previous stage (`c0` for j=0), appends it to the resolved sum, and registers the selected candidate's carry-out.

**Final stage outputs**
- `sum` is the full resolved sum.
- `cout` is the carry-out of the last block.
- `ovf = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1])`.
- `NB=1` degenerates to a single registered carry-select add. This is legal.

**Handshake and stall rules**
- `adv = !out_valid || out_ready`.
- `in_ready = adv`. This is combinational and has no dependency on `in_valid`.
- When `adv=1`:
  - every stage loads from its predecessor;
  - S1 loads `in_valid` together with the new operands.
- When `adv=0`:
  - every stage holds, including its valid bit and data;
  - no input is accepted.
- Bubbles do not collapse. The stall is global, not per stage.
- `out_valid`, `sum`, `cout` and `ovf` are driven directly from stage SNB's registers. They are held stable while `out_valid && !out_ready`.
- Data registers of invalid stages may take any value. Outputs are only meaningful when `out_valid=1`.

**Reset**
- While `rst_n=0` at a clock edge, all valid bits clear to 0, and `sum`, `cout` and `ovf` clear to 0.
- A reset asserted mid-operation discards all in-flight beats. No partial result is ever presented.
- During reset, `in_ready` reads 1, because `out_valid=0`. Any beat offered in the reset cycle is dropped.

## Timing
- Latency: a beat accepted at edge t (`in_valid && in_ready`) appears with `out_valid=1` after edge t+`NB-1`, i.e. visible in the cycle following the NB-th register load.
- Example: `WIDTH=16`, `BLK=4` gives `NB=4`. A beat accepted in cycle 0 is presented in cycle 4.
- Throughput is one beat per cycle while `out_ready=1`.
- Each stall cycle delays every in-flight beat by exactly one cycle.
- Critical path per stage: one BLK-bit adder pair plus one 2:1 mux. This is independent of `WIDTH`.
- On the first cycle after `rst_n` rises, the block accepts input; `out_valid` stays 0 for at least NB cycles.

## Test plan
All scenarios use `WIDTH=16`, `BLK=4`.

1. **Carry chain:** `a=0xFFFF`, `b=0x0001`, `cin=0`, `sub=0` → `sum=0x0000`, `cout=1`, `ovf=0`, with `out_valid` exactly 4 cycles after acceptance.
2. **Signed overflow and subtract:**
   - `0x7FFF+0x0001` → `sum=0x8000`, `cout=0`, `ovf=1`.
   - `sub=1`, `0x0005-0x0007` → `sum=0xFFFE`, `cout=0`, `ovf=0`.
   - `sub=1`, `0x8000-0x0001` → `sum=0x7FFF`, `cout=1`, `ovf=1`.
   - `sub=1` with `cin=1` gives the same results as with `cin=0`.
3. **Streaming:** 20 back-to-back random beats with `out_ready=1`.
   - 20 results arrive in order on consecutive cycles.
   - Each matches the reference model `{cout,sum} = a + bx + c0`.
   - `in_ready` stays 1 throughout.
4. **Backpressure:** hold `out_ready=0` for 3 cycles while `out_valid=1`.
   - `in_ready=0` during those cycles.
   - `sum`, `cout`, `ovf` and `out_valid` stay stable.
   - No beats are lost or duplicated, and ordering is preserved after release.
5. **Bubbles:** toggle `in_valid` in the pattern 1,0,1,0.
   - Outputs show the same valid/invalid pattern, shifted by 4 cycles.
6. **Reset mid-flight:** accept 3 beats, then drive `rst_n=0` for 1 cycle.
   - All outputs go to 0 at that edge.
   - None of the 3 beats ever appears.
   - A new beat accepted after reset yields the correct result 4 cycles later.

Source files
------------

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor. Each register stage resolves one BLK-bit block;
// a single global advance signal stalls the whole pipe when the consumer is not ready.
module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NB  = (BLK >= 1) ? WIDTH / BLK : 1;
  localparam int REM = (BLK >= 1) ? WIDTH % BLK : 0;

  if (BLK < 1 || REM != 0 || WIDTH < 1) begin : g_bad_cfg
    $error("csa_pipe: WIDTH must be a positive multiple of BLK, BLK >= 1");
  end

  logic                          adv;
  logic [WIDTH-1:0]              bx;
  logic                          c0;
  logic [NB-1:0][BLK:0]          e0, e1;

  // Stage registers; index k is stage S(k+1)
  logic [NB-1:0]                 vld_q, vld_d;
  logic [NB-1:0][WIDTH-1:0]      sum_q, sum_d, src_sum;
  logic [NB-1:0]                 cy_q, cy_d, src_cy;
  logic [NB-1:0][NB-1:0][BLK:0]  k0_q, k0_d, k1_q, k1_d;
  logic [NB-1:0]                 am_q, am_d, bm_q, bm_d;
  logic [NB-1:0][BLK:0]          sel;
  logic                          ovf_q, ovf_d;

  assign adv      = !vld_q[NB-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    bx = sub ? ~b : b;
    c0 = sub | cin;
    for (int j = 0; j < NB; j++) begin
      e0[j] = {1'b0, a[j*BLK +: BLK]} + {1'b0, bx[j*BLK +: BLK]};
      e1[j] = {1'b0, a[j*BLK +: BLK]} + {1'b0, bx[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    vld_d[0]   = in_valid;
    k0_d[0]    = e0;
    k1_d[0]    = e1;
    am_d[0]    = a[WIDTH-1];
    bm_d[0]    = bx[WIDTH-1];
    src_sum[0] = '0;
    src_cy[0]  = c0;
    for (int k = 1; k < NB; k++) begin
      vld_d[k]   = vld_q[k-1];
      k0_d[k]    = k0_q[k-1];
      k1_d[k]    = k1_q[k-1];
      am_d[k]    = am_q[k-1];
      bm_d[k]    = bm_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_cy[k]  = cy_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      sel[k]                    = src_cy[k] ? k1_d[k][k] : k0_d[k][k];
      sum_d[k]                  = src_sum[k];
      sum_d[k][k*BLK +: BLK]    = sel[k][BLK-1:0];
      cy_d[k]                   = sel[k][BLK];
    end
    ovf_d = (am_d[NB-1] == bm_d[NB-1]) && (sum_d[NB-1][WIDTH-1] != am_d[NB-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum_q <= '0;
      cy_q  <= '0;
      k0_q  <= '0;
      k1_q  <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q <= vld_d;
      sum_q <= sum_d;
      cy_q  <= cy_d;
      k0_q  <= k0_d;
      k1_q  <= k1_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  // The last stage's candidate and MSB copies have no further consumer
  logic unused_tail;
  assign unused_tail = ^{k0_q[NB-1], k1_q[NB-1], am_q[NB-1], bm_q[NB-1]};

  assign out_valid = vld_q[NB-1];
  assign sum       = sum_q[NB-1];
  assign cout      = cy_q[NB-1];
  assign ovf       = ovf_q;

endmodule
